multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences the shared multi-cycle MIPS datapath: one ALU, one unified memory, IR, PC.
//  Decodes op[5:0] from the latched IR and walks FETCH/DECODE/EXEC/MEM/WB steps.
//  Drives every mux select and write enable, and waits on a memory ready handshake.
//  Sits beside the datapath top; replaces the single-cycle EX/M/WB decode for the multi-cycle core.
// PARAMETERS
//  WAIT_LIMIT  15  max cycles a memory state waits for mem_ready before the error trap (>=1)
// PORTS
//  clk          in   1  rising-edge clock, only clock
//  rst_n        in   1  asynchronous active-low reset
//  op           in   6  IR[31:26], valid from DECODE onward
//  zero         in   1  ALU zero flag (used by datapath with PCWriteCond)
//  mem_ready    in   1  memory completes the current read/write this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if zero (beq)
//  IorD         out  1  mem address: 0=PC, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  latch instruction
//  MemtoReg     out  1  RF write data: 0=ALUOut, 1=MDR
//  RegDst       out  1  RF dest: 0=rt, 1=rd
//  RegWrite     out  1  RF write enable
//  ALUSrcA      out  1  0=PC, 1=rs
//  ALUSrcB      out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
//  ALUOp        out  2  00=add, 01=sub, 10=funct, 11=unused
//  PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  state_o      out  4  current state encoding (debug)
//  err          out  1  sticky: illegal opcode or memory timeout
// BEHAVIOUR
//  States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 RWB=7
//   BRANCH=8 JUMP=9 ADDIEX=10 ADDIWB=11 TRAP=12; codes 13-15 go to TRAP next cycle.
//  Reset: state=FETCH, wait counter=0, err=0. While rst_n low, all enables and selects are 0.
//  Outputs are pure functions of state, plus mem_ready for gating. Unlisted outputs are 0.
//  FETCH: MemRead=1, ALUSrcB=01. IRWrite=PCWrite=mem_ready. On mem_ready go to DECODE; else stay.
//  DECODE: ALUSrcB=11 (branch target into ALUOut). Next state by op:
//   000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->TRAP.
//  MEMADR: ALUSrcA=1, ALUSrcB=10. Next is MEMRD if op=100011, else MEMWR.
//  MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then go to MEMWB.
//  MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next is FETCH.
//  MEMWR: MemWrite=1, IorD=1. Wait for mem_ready, then go to FETCH.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is RWB.
//  RWB: RegWrite=1, RegDst=1. Next is FETCH.
//  BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Next is FETCH.
//  JUMP: PCWrite=1, PCSource=10. Next is FETCH.
//  ADDIEX: ALUSrcA=1, ALUSrcB=10. Next is ADDIWB.
//  ADDIWB: RegWrite=1. Next is FETCH.
//  TRAP: err=1 and all enables 0. Only reset exits TRAP.
//  Memory wait rule (FETCH/MEMRD/MEMWR):
//   - Request is held constant while waiting.
//   - Counter increments each cycle without mem_ready and clears on state exit.
//   - If counter reaches WAIT_LIMIT with mem_ready still low, go to TRAP.
//   - mem_ready in that same cycle wins: normal transition.
//  Latency (mem_ready tied 1): R/addi/sw 4 cycles, lw 5, beq/j 3.
//  Reset mid-instruction aborts immediately; no partial write issues after rst_n deasserts.
// TESTING
//  R-type: op=000000, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 with RegDst=1 only in RWB.
//  lw: op=100011, mem_ready low 3 cycles in MEMRD -> MemRead/IorD held; MEMWB one cycle after ready; total 8 cycles.
//  beq/j: op=000100 -> PCWriteCond=1, PCSource=01 in state 8; op=000010 -> PCWrite=1, PCSource=10 in state 9.
//  Illegal: op=111111 -> DECODE->TRAP, err=1 sticky, enables 0 for 20 cycles; rst_n pulse -> FETCH, err=0.
//  Timeout: FETCH with mem_ready=0 -> TRAP after WAIT_LIMIT=15 cycles; ready on cycle 15 -> DECODE instead.
//  Async reset: drop rst_n mid-MEMWR, between clocks -> all outputs 0 at once; state_o=0 after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multi-cycle MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB steps.
// Latency: R/addi/sw 4 cycles, lw 5, beq/j 3 with memory ready; outputs decode from the current state.
// Backpressure: memory states hold their request until mem_ready, trapping after WAIT_LIMIT idle cycles.
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_o,
    output logic       err
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    logic          is_mem, timeout;

    // The zero flag is consumed by the datapath together with PCWriteCond.
    logic unused_zero;
    assign unused_zero = zero;

    assign is_mem  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign timeout = (wait_cnt == CW'(WAIT_LIMIT - 1)) && !mem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (mem_ready) state_nxt = DECODE; else if (timeout) state_nxt = TRAP;
            DECODE: begin
                case (op)
                    6'b000000:            state_nxt = EXEC;
                    6'b100011, 6'b101011: state_nxt = MEMADR;
                    6'b000100:            state_nxt = BRANCH;
                    6'b000010:            state_nxt = JUMP;
                    6'b001000:            state_nxt = ADDIEX;
                    default:              state_nxt = TRAP;
                endcase
            end
            MEMADR: state_nxt = (op == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_nxt = MEMWB; else if (timeout) state_nxt = TRAP;
            MEMWR:  if (mem_ready) state_nxt = FETCH; else if (timeout) state_nxt = TRAP;
            EXEC:   state_nxt = RWB;
            ADDIEX: state_nxt = ADDIWB;
            MEMWB, RWB, BRANCH, JUMP, ADDIWB: state_nxt = FETCH;
            TRAP:   state_nxt = TRAP;
            default: state_nxt = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            // Counts only consecutive stalled cycles of the current memory state.
            if (is_mem && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state_nxt == TRAP)
                err_q <= 1'b1;
        end
    end

    // Outputs are gated by rst_n so an asserted reset silences the datapath without waiting for a clock.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (rst_n) begin
            case (state)
                FETCH:  begin MemRead = 1'b1; ALUSrcB = 2'b01; IRWrite = mem_ready; PCWrite = mem_ready; end
                DECODE: ALUSrcB = 2'b11;
                MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
                MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
                MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
                MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
                EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
                RWB:    begin RegWrite = 1'b1; RegDst = 1'b1; end
                BRANCH: begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01; end
                JUMP:   begin PCWrite = 1'b1; PCSource = 2'b10; end
                ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
                ADDIWB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state;
    assign err     = rst_n & err_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, memory stalls, timeout and reset.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_o;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state_o(state_o), .err(err)
    );

    always #5 clk = ~clk;

    // {err, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
    //  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
    logic [16:0] outs;
    assign outs = {err, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    localparam logic [16:0] O_FETCH_RDY = 17'h09410;
    localparam logic [16:0] O_FETCH_WT  = 17'h01010;
    localparam logic [16:0] O_DECODE    = 17'h00030;
    localparam logic [16:0] O_MEMADR    = 17'h00060;
    localparam logic [16:0] O_MEMRD     = 17'h03000;
    localparam logic [16:0] O_MEMWB     = 17'h00280;
    localparam logic [16:0] O_MEMWR     = 17'h02800;
    localparam logic [16:0] O_EXEC      = 17'h00048;
    localparam logic [16:0] O_RWB       = 17'h00180;
    localparam logic [16:0] O_BRANCH    = 17'h04045;
    localparam logic [16:0] O_JUMP      = 17'h08002;
    localparam logic [16:0] O_ADDIEX    = 17'h00060;
    localparam logic [16:0] O_ADDIWB    = 17'h00080;
    localparam logic [16:0] O_TRAP      = 17'h10000;
    localparam logic [16:0] O_ZERO      = 17'h00000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive mem_ready for one cycle, check state and outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic rdy, input int st, input logic [16:0] o);
        mem_ready = rdy;
        #1;
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_outs"}, 32'(outs), 32'(o));
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_outs", 32'(outs), 32'(O_ZERO));
        check("rst_state", 32'(state_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        check("por_outs", 32'(outs), 32'(O_ZERO));
        check("por_state", 32'(state_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type, 4 cycles
        op = 6'b000000;
        cyc("r_fetch", 1'b1, 0, O_FETCH_RDY);
        cyc("r_decode", 1'b1, 1, O_DECODE);
        cyc("r_exec", 1'b1, 6, O_EXEC);
        cyc("r_rwb", 1'b1, 7, O_RWB);

        // lw with three stalled MEMRD cycles, 8 cycles total
        op = 6'b100011;
        cyc("lw_fetch", 1'b1, 0, O_FETCH_RDY);
        cyc("lw_decode", 1'b1, 1, O_DECODE);
        cyc("lw_memadr", 1'b1, 2, O_MEMADR);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0, 3, O_MEMRD);
        cyc("lw_memrd_rdy", 1'b1, 3, O_MEMRD);
        cyc("lw_memwb", 1'b1, 4, O_MEMWB);

        // sw
        op = 6'b101011;
        cyc("sw_fetch", 1'b1, 0, O_FETCH_RDY);
        cyc("sw_decode", 1'b1, 1, O_DECODE);
        cyc("sw_memadr", 1'b1, 2, O_MEMADR);
        cyc("sw_memwr", 1'b1, 5, O_MEMWR);

        // beq, j, addi
        op = 6'b000100;
        cyc("beq_fetch", 1'b1, 0, O_FETCH_RDY);
        cyc("beq_decode", 1'b1, 1, O_DECODE);
        cyc("beq_branch", 1'b1, 8, O_BRANCH);
        op = 6'b000010;
        cyc("j_fetch", 1'b1, 0, O_FETCH_RDY);
        cyc("j_decode", 1'b1, 1, O_DECODE);
        cyc("j_jump", 1'b1, 9, O_JUMP);
        op = 6'b001000;
        cyc("addi_fetch", 1'b1, 0, O_FETCH_RDY);
        cyc("addi_decode", 1'b1, 1, O_DECODE);
        cyc("addi_ex", 1'b1, 10, O_ADDIEX);
        cyc("addi_wb", 1'b1, 11, O_ADDIWB);

        // Ready arriving on the 15th stalled cycle still wins over the timeout
        op = 6'b000010;
        for (int i = 0; i < 14; i++) cyc("to_edge_wait", 1'b0, 0, O_FETCH_WT);
        cyc("to_edge_rdy", 1'b1, 0, O_FETCH_RDY);
        cyc("to_edge_decode", 1'b1, 1, O_DECODE);
        cyc("to_edge_jump", 1'b1, 9, O_JUMP);

        // Fifteen stalled FETCH cycles trap
        for (int i = 0; i < 15; i++) cyc("to_wait", 1'b0, 0, O_FETCH_WT);
        cyc("to_trap", 1'b1, 12, O_TRAP);
        reset_pulse();
        cyc("to_after_rst", 1'b1, 0, O_FETCH_RDY);

        // Illegal opcode traps from DECODE and stays there
        op = 6'b111111;
        cyc("ill_decode", 1'b1, 1, O_DECODE);
        for (int i = 0; i < 20; i++) cyc("ill_trap", (i % 2) == 0, 12, O_TRAP);
        reset_pulse();
        cyc("ill_after_rst", 1'b1, 0, O_FETCH_RDY);

        // Asynchronous reset in the middle of a stalled MEMWR
        op = 6'b101011;
        cyc("ar_decode", 1'b1, 1, O_DECODE);
        cyc("ar_memadr", 1'b1, 2, O_MEMADR);
        cyc("ar_memwr", 1'b0, 5, O_MEMWR);
        mem_ready = 1'b0;
        reset_pulse();
        cyc("ar_after_rst", 1'b1, 0, O_FETCH_RDY);
        cyc("ar_decode2", 1'b1, 1, O_DECODE);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
